// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for a 15-instruction MIPS subset.
// It drives one shared memory with a ready handshake and raises a sticky bus error on timeout.
module multi_cycle_ctrl #(
    parameter int WAIT_MAX = 15,
    parameter int CW       = 4
) (
    input  logic       Clk,
    input  logic       Clrn,
    input  logic [5:0] Op,
    input  logic [5:0] Func,
    input  logic       Z,
    input  logic       Mem_rdy,
    output logic       Mem_req,
    output logic       Iord,
    output logic       Mem_we,
    output logic       Ir_we,
    output logic       Pc_we,
    output logic [2:0] Pcsrc,
    output logic       Wreg,
    output logic       Regrt,
    output logic       Se,
    output logic       Aluqb,
    output logic [2:0] Aluc,
    output logic       Reg2reg,
    output logic       Retire,
    output logic       Illegal,
    output logic       Bus_err,
    output logic [2:0] State
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                           OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                           OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_LUI  = 6'h0F,
                           OP_LW    = 6'h23, OP_SW   = 6'h2B;
    localparam logic [5:0] FN_JR = 6'h08, FN_ADDU = 6'h21, FN_SUBU = 6'h23,
                           FN_AND = 6'h24, FN_OR = 6'h25;
    localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                           ALU_OR  = 3'b011, ALU_LUI = 3'b100;
    localparam logic [2:0] PC_SEQ = 3'b000, PC_BR = 3'b010, PC_J = 3'b011,
                           PC_JAL = 3'b100, PC_JR = 3'b101;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          berr_set;

    logic       d_legal, d_alu, d_sw, d_beq, d_bne, d_j, d_jr, d_jal;
    logic       d_regrt, d_se, d_aluqb, d_r2r;
    logic [2:0] d_aluc;
    logic       br_take;

    always_comb begin
        d_legal = 1'b1;
        d_alu   = 1'b0;
        d_sw    = 1'b0;
        d_beq   = 1'b0;
        d_bne   = 1'b0;
        d_j     = 1'b0;
        d_jr    = 1'b0;
        d_jal   = 1'b0;
        d_regrt = 1'b0;
        d_se    = 1'b0;
        d_aluqb = 1'b0;
        d_aluc  = ALU_ADD;
        d_r2r   = 1'b1;
        case (Op)
            OP_RTYPE: begin
                d_aluqb = 1'b1;
                case (Func)
                    FN_ADDU: d_alu = 1'b1;
                    FN_SUBU: begin d_alu = 1'b1; d_aluc = ALU_SUB; end
                    FN_AND:  begin d_alu = 1'b1; d_aluc = ALU_AND; end
                    FN_OR:   begin d_alu = 1'b1; d_aluc = ALU_OR;  end
                    FN_JR:   d_jr = 1'b1;
                    default: d_legal = 1'b0;
                endcase
            end
            OP_ADDI: begin d_alu = 1'b1; d_regrt = 1'b1; d_se = 1'b1; end
            OP_ANDI: begin d_alu = 1'b1; d_regrt = 1'b1; d_aluc = ALU_AND; end
            OP_ORI:  begin d_alu = 1'b1; d_regrt = 1'b1; d_aluc = ALU_OR; end
            OP_LUI:  begin d_alu = 1'b1; d_regrt = 1'b1; d_se = 1'b1; d_aluc = ALU_LUI; end
            OP_LW:   begin d_regrt = 1'b1; d_se = 1'b1; d_r2r = 1'b0; end
            OP_SW:   begin d_sw = 1'b1; d_regrt = 1'b1; d_se = 1'b1; end
            OP_BEQ:  begin d_beq = 1'b1; d_regrt = 1'b1; d_se = 1'b1; d_aluqb = 1'b1; d_aluc = ALU_SUB; end
            OP_BNE:  begin d_bne = 1'b1; d_regrt = 1'b1; d_se = 1'b1; d_aluqb = 1'b1; d_aluc = ALU_SUB; end
            OP_J:    d_j = 1'b1;
            OP_JAL:  begin d_jal = 1'b1; d_regrt = 1'b1; end
            default: d_legal = 1'b0;
        endcase
        // An undecoded instruction drives no datapath selects at all
        if (!d_legal) begin
            d_regrt = 1'b0;
            d_se    = 1'b0;
            d_aluqb = 1'b0;
            d_aluc  = ALU_ADD;
            d_r2r   = 1'b0;
        end
    end

    assign br_take = d_beq ? Z : ~Z;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        berr_set  = 1'b0;
        Mem_req   = 1'b0;
        Iord      = 1'b0;
        Mem_we    = 1'b0;
        Ir_we     = 1'b0;
        Pc_we     = 1'b0;
        Pcsrc     = PC_SEQ;
        Wreg      = 1'b0;
        Regrt     = 1'b0;
        Se        = 1'b0;
        Aluqb     = 1'b0;
        Aluc      = ALU_ADD;
        Reg2reg   = 1'b0;
        Retire    = 1'b0;
        Illegal   = 1'b0;

        // IR is only trustworthy after the fetch, so selects follow decode from ID on
        if (state inside {S_ID, S_EX, S_MEM, S_WB}) begin
            Regrt   = d_regrt;
            Se      = d_se;
            Aluqb   = d_aluqb;
            Aluc    = d_aluc;
            Reg2reg = d_r2r;
        end

        case (state)
            S_IF: begin
                Mem_req = 1'b1;
                if (Mem_rdy) begin
                    Ir_we     = 1'b1;
                    Pc_we     = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_ID;
                end else if (cnt == CW'(WAIT_MAX)) begin
                    berr_set  = 1'b1;
                    state_nxt = S_HALT;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_ID: begin
                state_nxt = S_IF;
                if (!d_legal) begin
                    Illegal = 1'b1;
                    Retire  = 1'b1;
                end else if (d_j) begin
                    Pc_we  = 1'b1;
                    Pcsrc  = PC_J;
                    Retire = 1'b1;
                end else if (d_jr) begin
                    Pc_we  = 1'b1;
                    Pcsrc  = PC_JR;
                    Retire = 1'b1;
                end else if (d_jal) begin
                    Wreg   = 1'b1;
                    Pc_we  = 1'b1;
                    Pcsrc  = PC_JAL;
                    Retire = 1'b1;
                end else begin
                    state_nxt = S_EX;
                end
            end
            S_EX: begin
                if (d_beq || d_bne) begin
                    Pc_we     = br_take;
                    Pcsrc     = br_take ? PC_BR : PC_SEQ;
                    Retire    = 1'b1;
                    state_nxt = S_IF;
                end else if (d_alu) begin
                    state_nxt = S_WB;
                end else begin
                    state_nxt = S_MEM;
                end
            end
            S_MEM: begin
                Mem_req = 1'b1;
                Iord    = 1'b1;
                Mem_we  = d_sw;
                if (Mem_rdy) begin
                    cnt_nxt   = '0;
                    Retire    = d_sw;
                    state_nxt = d_sw ? S_IF : S_WB;
                end else if (cnt == CW'(WAIT_MAX)) begin
                    berr_set  = 1'b1;
                    state_nxt = S_HALT;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_WB: begin
                Wreg      = 1'b1;
                Retire    = 1'b1;
                state_nxt = S_IF;
            end
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_IF;
        endcase

        // Reset must never leak a write, even for the cycle Clrn falls mid-instruction
        if (!Clrn) begin
            Mem_req = 1'b0;
            Iord    = 1'b0;
            Mem_we  = 1'b0;
            Ir_we   = 1'b0;
            Pc_we   = 1'b0;
            Pcsrc   = PC_SEQ;
            Wreg    = 1'b0;
            Regrt   = 1'b0;
            Se      = 1'b0;
            Aluqb   = 1'b0;
            Aluc    = ALU_ADD;
            Reg2reg = 1'b0;
            Retire  = 1'b0;
            Illegal = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state   <= S_IF;
            cnt     <= '0;
            Bus_err <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (berr_set) Bus_err <= 1'b1;
        end
    end

    assign State = state;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: expected output vectors are queued per cycle
// and checked against the DUT at the falling edge.
module tb_multi_cycle_ctrl;

    localparam int WAIT_MAX = 15;

    logic       Clk, Clrn;
    logic [5:0] Op, Func;
    logic       Z, Mem_rdy;
    logic       Mem_req, Iord, Mem_we, Ir_we, Pc_we;
    logic [2:0] Pcsrc;
    logic       Wreg, Regrt, Se, Aluqb;
    logic [2:0] Aluc;
    logic       Reg2reg, Retire, Illegal, Bus_err;
    logic [2:0] State;

    multi_cycle_ctrl #(.WAIT_MAX(WAIT_MAX), .CW(4)) dut (
        .Clk(Clk), .Clrn(Clrn), .Op(Op), .Func(Func), .Z(Z), .Mem_rdy(Mem_rdy),
        .Mem_req(Mem_req), .Iord(Iord), .Mem_we(Mem_we), .Ir_we(Ir_we), .Pc_we(Pc_we),
        .Pcsrc(Pcsrc), .Wreg(Wreg), .Regrt(Regrt), .Se(Se), .Aluqb(Aluqb), .Aluc(Aluc),
        .Reg2reg(Reg2reg), .Retire(Retire), .Illegal(Illegal), .Bus_err(Bus_err),
        .State(State)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // select group: {Regrt, Se, Aluqb, Aluc[2:0], Reg2reg}
    localparam logic [6:0] S_ADDU = 7'b0_0_1_000_1, S_LW  = 7'b1_1_0_000_0,
                           S_SW   = 7'b1_1_0_000_1, S_BR  = 7'b1_1_1_001_1,
                           S_JAL  = 7'b1_0_0_000_1, S_ORI = 7'b1_0_0_011_1,
                           S_SUBU = 7'b0_0_1_001_1, S_LUI = 7'b1_1_0_100_1,
                           S_ZERO = 7'b0;
    localparam logic [6:0] C_NONE = 7'b0, C_EX = 7'b0_1_1_111_0,
                           C_RT = 7'b1_0_0_000_0, C_ALL = 7'b1_1_1_111_1;

    typedef struct {
        string       tag;
        logic [21:0] v;
        logic [21:0] c;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic logic [43:0] ev(input logic [2:0] st, input logic req, iord, mwe, irwe, pcwe,
                                       input logic [2:0] pcsrc, input logic wreg,
                                       input logic [6:0] sel, input logic [6:0] selc,
                                       input logic ret, ill, berr);
        logic [21:0] v, c;
        v = {st, req, iord, mwe, irwe, pcwe, pcsrc, wreg, sel, ret, ill, berr};
        c = {12'hFFF, selc, 3'b111};
        return {c, v};
    endfunction

    task automatic cyc(input string tag, input logic rdy, input logic z, input logic [43:0] e);
        exp_t        x;
        logic [21:0] obs;
        Mem_rdy = rdy;
        Z       = z;
        x.tag = tag;
        x.v   = e[21:0];
        x.c   = e[43:22];
        sb.push_back(x);
        @(negedge Clk);
        x   = sb.pop_front();
        obs = {State, Mem_req, Iord, Mem_we, Ir_we, Pc_we, Pcsrc, Wreg,
               Regrt, Se, Aluqb, Aluc, Reg2reg, Retire, Illegal, Bus_err};
        n_assert++;
        assert ((obs & x.c) === (x.v & x.c)) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", x.tag, obs & x.c, x.v & x.c);
        end
        @(posedge Clk);
        #1;
    endtask

    // fetch completes at once; IR contents are don't-care for the selects here
    task automatic fetch(input string tag, input logic [5:0] op, input logic [5:0] fn);
        Op   = op;
        Func = fn;
        cyc(tag, 1'b1, 1'b0, ev(3'd0, 1, 0, 0, 1, 1, 3'b000, 0, S_ZERO, C_NONE, 0, 0, 0));
    endtask

    task automatic id_go(input string tag);
        cyc(tag, 1'b1, 1'b0, ev(3'd1, 0, 0, 0, 0, 0, 3'b000, 0, S_ZERO, C_NONE, 0, 0, 0));
    endtask

    task automatic alu_op(input string tag, input logic [5:0] op, input logic [5:0] fn,
                          input logic [6:0] sel);
        fetch({tag, "_if"}, op, fn);
        id_go({tag, "_id"});
        cyc({tag, "_ex"}, 1'b1, 1'b0, ev(3'd2, 0, 0, 0, 0, 0, 3'b000, 0, sel, C_EX, 0, 0, 0));
        cyc({tag, "_wb"}, 1'b1, 1'b0, ev(3'd4, 0, 0, 0, 0, 0, 3'b000, 1, sel, C_ALL, 1, 0, 0));
    endtask

    task automatic branch(input string tag, input logic [5:0] op, input logic z, input logic take);
        fetch({tag, "_if"}, op, 6'h00);
        id_go({tag, "_id"});
        cyc({tag, "_ex"}, 1'b1, z, ev(3'd2, 0, 0, 0, 0, take, take ? 3'b010 : 3'b000, 0,
                                      S_BR, C_EX, 1, 0, 0));
    endtask

    initial begin
        Clrn    = 1'b0;
        Op      = 6'h00;
        Func    = 6'h00;
        Z       = 1'b0;
        Mem_rdy = 1'b1;

        for (int i = 0; i < 3; i++)
            cyc("reset", 1'b1, 1'b0, ev(3'd0, 0, 0, 0, 0, 0, 3'b000, 0, S_ZERO, C_ALL, 0, 0, 0));

        Clrn = 1'b1;
        alu_op("addu", 6'h00, 6'h21, S_ADDU);
        alu_op("subu", 6'h00, 6'h23, S_SUBU);
        alu_op("ori", 6'h0D, 6'h00, S_ORI);
        alu_op("lui", 6'h0F, 6'h00, S_LUI);

        // lw with three wait cycles in MEM: 8 cycles in all
        fetch("lw_if", 6'h23, 6'h00);
        id_go("lw_id");
        cyc("lw_ex", 1'b1, 1'b0, ev(3'd2, 0, 0, 0, 0, 0, 3'b000, 0, S_LW, C_EX, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            cyc("lw_mem", (i == 3), 1'b0, ev(3'd3, 1, 1, 0, 0, 0, 3'b000, 0, S_LW, C_EX, 0, 0, 0));
        cyc("lw_wb", 1'b1, 1'b0, ev(3'd4, 0, 0, 0, 0, 0, 3'b000, 1, S_LW, C_ALL, 1, 0, 0));

        fetch("sw_if", 6'h2B, 6'h00);
        id_go("sw_id");
        cyc("sw_ex", 1'b1, 1'b0, ev(3'd2, 0, 0, 0, 0, 0, 3'b000, 0, S_SW, C_EX, 0, 0, 0));
        cyc("sw_mem", 1'b1, 1'b0, ev(3'd3, 1, 1, 1, 0, 0, 3'b000, 0, S_SW, C_EX, 1, 0, 0));

        branch("beq_t", 6'h04, 1'b1, 1'b1);
        branch("beq_n", 6'h04, 1'b0, 1'b0);
        branch("bne_n", 6'h05, 1'b1, 1'b0);
        branch("bne_t", 6'h05, 1'b0, 1'b1);

        fetch("jal_if", 6'h03, 6'h00);
        cyc("jal_id", 1'b1, 1'b0, ev(3'd1, 0, 0, 0, 0, 1, 3'b100, 1, S_JAL, C_RT, 1, 0, 0));
        fetch("jr_if", 6'h00, 6'h08);
        cyc("jr_id", 1'b1, 1'b0, ev(3'd1, 0, 0, 0, 0, 1, 3'b101, 0, S_ZERO, C_NONE, 1, 0, 0));
        fetch("j_if", 6'h02, 6'h00);
        cyc("j_id", 1'b1, 1'b0, ev(3'd1, 0, 0, 0, 0, 1, 3'b011, 0, S_ZERO, C_NONE, 1, 0, 0));
        fetch("ill_op_if", 6'h3F, 6'h00);
        cyc("ill_op_id", 1'b1, 1'b0, ev(3'd1, 0, 0, 0, 0, 0, 3'b000, 0, S_ZERO, C_NONE, 1, 1, 0));
        fetch("ill_fn_if", 6'h00, 6'h00);
        cyc("ill_fn_id", 1'b1, 1'b0, ev(3'd1, 0, 0, 0, 0, 0, 3'b000, 0, S_ZERO, C_NONE, 1, 1, 0));

        // reset mid-instruction: a taken beq in EX must not write the PC
        fetch("abort_if", 6'h04, 6'h00);
        id_go("abort_id");
        Clrn = 1'b0;
        cyc("abort_ex", 1'b1, 1'b1, ev(3'd0, 0, 0, 0, 0, 0, 3'b000, 0, S_ZERO, C_ALL, 0, 0, 0));
        Clrn = 1'b1;

        // ready arrives exactly on the last allowed wait cycle: no error
        Op = 6'h02;
        for (int i = 0; i < WAIT_MAX; i++)
            cyc("edge_wait", 1'b0, 1'b0, ev(3'd0, 1, 0, 0, 0, 0, 3'b000, 0, S_ZERO, C_NONE, 0, 0, 0));
        fetch("edge_rdy", 6'h02, 6'h00);
        cyc("edge_j_id", 1'b1, 1'b0, ev(3'd1, 0, 0, 0, 0, 1, 3'b011, 0, S_ZERO, C_NONE, 1, 0, 0));

        // one wait too many: bus error and HALT
        for (int i = 0; i <= WAIT_MAX; i++)
            cyc("to_wait", 1'b0, 1'b0, ev(3'd0, 1, 0, 0, 0, 0, 3'b000, 0, S_ZERO, C_NONE, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            cyc("halt", 1'b1, 1'b1, ev(3'd7, 0, 0, 0, 0, 0, 3'b000, 0, S_ZERO, C_ALL, 0, 0, 1));

        Clrn = 1'b0;
        cyc("clr_berr", 1'b1, 1'b0, ev(3'd0, 0, 0, 0, 0, 0, 3'b000, 0, S_ZERO, C_ALL, 0, 0, 0));
        Clrn = 1'b1;
        alu_op("post_addu", 6'h00, 6'h21, S_ADDU);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
